// File: rtl/check_sequencer.sv
// Purpose : sequences one write-path data checker through a single host-commanded check run.
// Latency : CLEAR 1 cycle, RUN until last word/abort/timeout, SETTLE CHECK_LAT cycles, DONE 1 cycle.
// Backpr. : none; the checker is slaved to data_valid, start while busy is dropped.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   start, abort           one-cycle host command pulses
//   pattern_sel, word_count run setup, latched on an accepted start
//   data_valid             one word presented to the checker this cycle
//   error_count_in         checker error count, sampled once it has settled
//   pattern_out, reset_pattern, reset_err_counter, enable_pattern, check_for_errors
//                          checker controls
//   busy, done, words_checked, error_snapshot, timed_out, aborted, pass
//                          host status
module check_sequencer #(
  parameter int CHECK_LAT      = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      pattern_sel,
  input  logic [CNT_W-1:0] word_count,
  input  logic             data_valid,
  input  logic [31:0]      error_count_in,
  output logic [31:0]      pattern_out,
  output logic             reset_pattern,
  output logic             reset_err_counter,
  output logic             enable_pattern,
  output logic             check_for_errors,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_checked,
  output logic [31:0]      error_snapshot,
  output logic             timed_out,
  output logic             aborted,
  output logic             pass
);

  // Settle counter only has to reach CHECK_LAT-1; a CHECK_LAT of 0 behaves as 1.
  localparam int SW = (CHECK_LAT < 2) ? 1 : $clog2(CHECK_LAT);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'((CHECK_LAT > 0) ? CHECK_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      pattern_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic [SW-1:0]    settle_q;
  logic [31:0]      snap_q;
  logic             timed_out_q;
  logic             aborted_q;
  logic             pass_q;

  logic last_word;
  logic timeout_hit;
  logic settle_last;
  logic word_ok;

  // A word is only counted while below the latched count, so the counter
  // can never pass the count or wrap even if the exit logic is bypassed.
  assign word_ok     = data_valid && (words_q != cnt_q);
  assign last_word   = data_valid && ((words_q + CNT_W'(1)) == cnt_q);
  assign timeout_hit = !data_valid && (to_cnt_q == TO_LAST);
  assign settle_last = (settle_q == SETTLE_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and checker/host control outputs. Controls decode from the
  // state register, so an asynchronous reset drops them immediately.
  always_comb begin
    state_d           = state_q;
    reset_pattern     = 1'b0;
    reset_err_counter = 1'b0;
    enable_pattern    = 1'b0;
    check_for_errors  = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // abort in IDLE is dropped; start wins when both arrive together
        if (start) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        reset_pattern     = 1'b1;
        reset_err_counter = 1'b1;
        state_d           = (cnt_q == '0) ? S_SETTLE : S_RUN;
      end
      S_RUN: begin
        // the generator advances exactly once per presented word
        check_for_errors = data_valid;
        enable_pattern   = data_valid;
        if (abort || last_word || timeout_hit) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Run setup, counters and sticky status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q   <= '0;
      cnt_q       <= '0;
      words_q     <= '0;
      to_cnt_q    <= '0;
      settle_q    <= '0;
      snap_q      <= '0;
      timed_out_q <= 1'b0;
      aborted_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pattern_q   <= pattern_sel;
            cnt_q       <= word_count;
            words_q     <= '0;
            to_cnt_q    <= '0;
            settle_q    <= '0;
            snap_q      <= '0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        S_RUN: begin
          if (data_valid) begin
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
          if (word_ok) begin
            words_q <= words_q + CNT_W'(1);
          end
          // abort outranks the timeout; a last word never coincides with a
          // timeout because the timeout needs an empty cycle
          if (abort) begin
            aborted_q <= 1'b1;
          end else if (timeout_hit) begin
            timed_out_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q + SW'(1);
          if (settle_last) begin
            // error count has had CHECK_LAT cycles to absorb the last compare;
            // the verdict is formed here so it is already valid alongside done
            snap_q <= error_count_in;
            pass_q <= (error_count_in == 32'd0) && !timed_out_q && !aborted_q &&
                      (words_q == cnt_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pattern_out    = pattern_q;
  assign words_checked  = words_q;
  assign error_snapshot = snap_q;
  assign timed_out      = timed_out_q;
  assign aborted        = aborted_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_check_sequencer.sv
module tb_check_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] pattern_sel;
  logic [31:0] word_count;
  logic        data_valid;
  logic [31:0] error_count_in;
  logic [31:0] pattern_out;
  logic        reset_pattern;
  logic        reset_err_counter;
  logic        enable_pattern;
  logic        check_for_errors;
  logic        busy;
  logic        done;
  logic [31:0] words_checked;
  logic [31:0] error_snapshot;
  logic        timed_out;
  logic        aborted;
  logic        pass;

  int errs;
  int checks;

  check_sequencer #(
    .CHECK_LAT     (2),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .pattern_sel      (pattern_sel),
    .word_count       (word_count),
    .data_valid       (data_valid),
    .error_count_in   (error_count_in),
    .pattern_out      (pattern_out),
    .reset_pattern    (reset_pattern),
    .reset_err_counter(reset_err_counter),
    .enable_pattern   (enable_pattern),
    .check_for_errors (check_for_errors),
    .busy             (busy),
    .done             (done),
    .words_checked    (words_checked),
    .error_snapshot   (error_snapshot),
    .timed_out        (timed_out),
    .aborted          (aborted),
    .pass             (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s, a, d;
    logic [31:0] err, psel, wc;
    logic [31:0] pat;
    logic        rp, cfe, busy, done;
    logic [31:0] words, snap;
    logic        to, ab, pass;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic s, a, d, input logic [31:0] err, psel, wc,
                              input logic [31:0] pat, input logic rp, cfe, bsy, dn,
                              input logic [31:0] words, snap, input logic to, ab, ps);
    vec_t v;
    v.s = s; v.a = a; v.d = d; v.err = err; v.psel = psel; v.wc = wc;
    v.pat = pat; v.rp = rp; v.cfe = cfe; v.busy = bsy; v.done = dn;
    v.words = words; v.snap = snap; v.to = to; v.ab = ab; v.pass = ps;
    return v;
  endfunction

  function automatic logic [104:0] outs();
    return {pattern_out, reset_pattern, reset_err_counter, enable_pattern, check_for_errors,
            busy, done, words_checked, error_snapshot, timed_out, aborted, pass};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [104:0] got, input logic [104:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic cyc(input logic s, input logic a, input logic d, input logic [31:0] e);
    @(negedge clk);
    start = s;
    abort = a;
    data_valid = d;
    error_count_in = e;
    #1;
  endtask

  // Run n quiet cycles, recording done pulses, the first done cycle (1-based)
  // and how many cycles check_for_errors was high.
  task automatic run_quiet(input int n, input logic d, output int dones, output int first,
                           output int cfes);
    dones = 0;
    first = 0;
    cfes  = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(1'b0, 1'b0, d, 32'd0);
      if (done) begin
        dones++;
        if (first == 0) first = i;
      end
      if (check_for_errors) cfes++;
    end
  endtask

  initial begin
    int dones, first, cfes;
    vec_t v;
    errs = 0;
    checks = 0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern_sel = '0;
    word_count = '0;
    data_valid = 1'b0;
    error_count_in = '0;

    // run 1: 4 back-to-back words, clean -> pass
    tbl[0]  = mk(1,0,0,0,3,4, 0,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,3,4, 3,1,0,1,0, 0,0,0,0,0);
    tbl[2]  = mk(0,0,1,0,3,4, 3,0,1,1,0, 0,0,0,0,0);
    tbl[3]  = mk(0,0,1,0,3,4, 3,0,1,1,0, 1,0,0,0,0);
    tbl[4]  = mk(0,0,1,0,3,4, 3,0,1,1,0, 2,0,0,0,0);
    tbl[5]  = mk(0,0,1,0,3,4, 3,0,1,1,0, 3,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,3,4, 3,0,0,1,0, 4,0,0,0,0);
    tbl[7]  = mk(0,0,0,0,3,4, 3,0,0,1,0, 4,0,0,0,0);
    tbl[8]  = mk(0,0,0,0,3,4, 3,0,0,1,1, 4,0,0,0,1);
    tbl[9]  = mk(0,0,0,0,3,4, 3,0,0,0,0, 4,0,0,0,1);
    // run 2: 3 gapped words, start while busy ignored, errors=2 -> fail
    tbl[10] = mk(1,0,0,0,5,3, 3,0,0,0,0, 4,0,0,0,1);
    tbl[11] = mk(0,0,0,0,5,3, 5,1,0,1,0, 0,0,0,0,0);
    tbl[12] = mk(0,0,1,0,5,3, 5,0,1,1,0, 0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,5,3, 5,0,0,1,0, 1,0,0,0,0);
    tbl[14] = mk(1,0,0,0,9,1, 5,0,0,1,0, 1,0,0,0,0);
    tbl[15] = mk(0,0,1,0,5,3, 5,0,1,1,0, 1,0,0,0,0);
    tbl[16] = mk(0,0,0,0,5,3, 5,0,0,1,0, 2,0,0,0,0);
    tbl[17] = mk(0,0,1,0,5,3, 5,0,1,1,0, 2,0,0,0,0);
    tbl[18] = mk(0,0,1,2,5,3, 5,0,0,1,0, 3,0,0,0,0);
    tbl[19] = mk(0,0,0,2,5,3, 5,0,0,1,0, 3,0,0,0,0);
    tbl[20] = mk(0,0,0,0,5,3, 5,0,0,1,1, 3,2,0,0,0);
    tbl[21] = mk(0,0,0,0,5,3, 5,0,0,0,0, 3,2,0,0,0);

    #12;
    chkv("reset_outputs", outs(), 105'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      v = tbl[i];
      pattern_sel = v.psel;
      word_count  = v.wc;
      cyc(v.s, v.a, v.d, v.err);
      chkv($sformatf("vec%0d", i), outs(),
           {v.pat, v.rp, v.rp, v.cfe, v.cfe, v.busy, v.done, v.words, v.snap, v.to, v.ab, v.pass});
    end

    // run 3: abort together with the 6th word; start mid-run is ignored
    pattern_sel = 32'd7;
    word_count  = 32'd10;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pattern_sel = (i == 2) ? 32'hAA : 32'd7;
      word_count  = (i == 2) ? 32'd1 : 32'd10;
      cyc(i == 2, 0, 1, 0);
    end
    cyc(0, 1, 1, 0);
    chk("abort_word_checked", check_for_errors, 1);
    run_quiet(10, 0, dones, first, cfes);
    chk("abort_done_cycle", first, 3);
    chk("abort_done_count", dones, 1);
    chk("abort_words", words_checked, 6);
    chk("abort_flag", aborted, 1);
    chk("abort_pass", pass, 0);
    chk("abort_timed_out", timed_out, 0);
    chk("busy_start_pattern", pattern_out, 7);

    // run 4: 2 words then silence -> timeout after 8 empty cycles
    pattern_sel = 32'd1;
    word_count  = 32'd10;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("start_clears_aborted", aborted, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    run_quiet(20, 0, dones, first, cfes);
    chk("timeout_done_cycle", first, 11);
    chk("timeout_done_count", dones, 1);
    chk("timeout_flag", timed_out, 1);
    chk("timeout_words", words_checked, 2);
    chk("timeout_pass", pass, 0);

    // run 5: zero count, start+abort together, data_valid held high
    pattern_sel = 32'd2;
    word_count  = 32'd0;
    cyc(1, 1, 1, 0);
    run_quiet(10, 1, dones, first, cfes);
    chk("zero_done_cycle", first, 4);
    chk("zero_no_checks", cfes, 0);
    chk("zero_words", words_checked, 0);
    chk("zero_pass", pass, 1);
    chk("zero_abort_dropped", aborted, 0);
    chk("zero_timeout_cleared", timed_out, 0);

    // run 6: asynchronous reset mid-RUN with data_valid held
    pattern_sel = 32'd4;
    word_count  = 32'd10;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("pre_reset_check", check_for_errors, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chkv("async_reset_outputs", outs(), 105'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 0, 1, 0);
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_idle_check", check_for_errors, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
